// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function encodings, RV32I opcode constants,
// skid-buffer state type and the decoded issue-entry record.
package alu_pkg;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_t;

    typedef struct packed {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I ALU-class decoder producing operands,
// function code, destination and legality for one instruction word.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]  i_inst,
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_rs1_val,
    input  logic [31:0]  i_rs2_val,
    output issue_entry_t o_entry
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic        w_legal;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];
    assign w_rs1    = (i_inst[19:15] == 5'd0) ? '0 : i_rs1_val;
    assign w_rs2    = (i_inst[24:20] == 5'd0) ? '0 : i_rs2_val;
    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_u  = {i_inst[31:12], 12'b0};

    // Decode opcode class into operands/function; illegal words collapse to a zero-operand add
    always_comb begin
        o_entry    = '0;
        o_entry.rd = i_inst[11:7];
        w_legal    = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                o_entry.in0  = w_rs1;
                o_entry.in1  = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ?
                               {27'b0, w_rs2[4:0]} : w_rs2;
                o_entry.func = {i_inst[30], w_funct3};
                w_legal      = (w_funct7 == 7'b0000000) ||
                               (w_funct7 == 7'b0100000 &&
                                (w_funct3 == 3'b000 || w_funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                o_entry.in0 = w_rs1;
                case (w_funct3)
                    3'b001: begin
                        o_entry.in1  = {27'b0, i_inst[24:20]};
                        o_entry.func = FN_SLL;
                        w_legal      = (w_funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        o_entry.in1  = {27'b0, i_inst[24:20]};
                        o_entry.func = {i_inst[30], 3'b101};
                        w_legal      = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    end
                    default: begin
                        o_entry.in1  = w_imm_i;
                        o_entry.func = {1'b0, w_funct3};
                        w_legal      = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                o_entry.in0  = '0;
                o_entry.in1  = w_imm_u;
                o_entry.func = FN_ADD;
                w_legal      = 1'b1;
            end
            OPC_AUIPC: begin
                o_entry.in0  = i_pc;
                o_entry.in1  = w_imm_u;
                o_entry.func = FN_ADD;
                w_legal      = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (!w_legal) begin
            o_entry.in0  = '0;
            o_entry.in1  = '0;
            o_entry.func = FN_ADD;
        end
        o_entry.illegal = !w_legal;
        o_entry.wen     = w_legal && (o_entry.rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-to-ALU issue stage with a two-entry skid buffer.
// Optional result bypass enabled by defining macro ALU_FWD_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic            flush,
`ifdef ALU_FWD_EN
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in0,
    output logic [XLEN-1:0] alu_in1,
    output logic [3:0]      alu_func,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            illegal
);

    skid_state_t  r_state;
    issue_entry_t r_head;
    issue_entry_t r_skid;
    issue_entry_t w_dec;
    logic [31:0]  w_rs1_val;
    logic [31:0]  w_rs2_val;
    logic         w_push;
    logic         w_pop;

`ifdef ALU_FWD_EN
    // Bypass replaces the raw register value before decode, so shift masking still applies
    assign w_rs1_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[19:15]) ? fwd_data : in_rs1_val;
    assign w_rs2_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[24:20]) ? fwd_data : in_rs2_val;
`else
    assign w_rs1_val = in_rs1_val;
    assign w_rs2_val = in_rs2_val;
`endif

    alu_decode u_decode (
        .i_inst    (in_inst),
        .i_pc      (in_pc),
        .i_rs1_val (w_rs1_val),
        .i_rs2_val (w_rs2_val),
        .o_entry   (w_dec)
    );

    assign in_ready  = !rst && (r_state != SKID_FULL);
    assign out_valid = (r_state != SKID_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign alu_in0  = r_head.in0;
    assign alu_in1  = r_head.in1;
    assign alu_func = r_head.func;
    assign out_rd   = r_head.rd;
    assign out_wen  = r_head.wen;
    assign illegal  = r_head.illegal;

    // Skid-buffer FSM: head register drives the outputs, skid holds the second entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_dec;
                        r_state <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_dec;
                    end else if (w_push) begin
                        r_skid  <= w_dec;
                        r_state <= SKID_FULL;
                    end else if (w_pop) begin
                        r_state <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_state <= SKID_ONE;
                    end
                end
                default: r_state <= SKID_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue; driver pushes hand-computed
// expectations at acceptance, a negedge monitor pops and compares on output pops.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        flush;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [3:0]  alu_func;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .flush      (flush),
`ifdef ALU_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_in0    (alu_in0),
        .alu_in1    (alu_in1),
        .alu_func   (alu_func),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .illegal    (illegal)
    );

    typedef struct {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        m_exp;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    function automatic exp_t mk(input logic [31:0] in0, input logic [31:0] in1, input logic [3:0] func,
                                input logic [4:0] rd, input logic wen, input logic ill, input string name);
        exp_t e;
        e.in0 = in0; e.in1 = in1; e.func = func; e.rd = rd; e.wen = wen; e.ill = ill; e.name = name;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: each negedge where a pop will occur, compare the presented entry with the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got in0=0x%08h func=%h rd=%0d, expected no entry", alu_in0, alu_func, out_rd);
            end else begin
                m_exp = q.pop_front();
                check({m_exp.name, ".in0"},  alu_in0, m_exp.in0);
                check({m_exp.name, ".in1"},  alu_in1, m_exp.in1);
                check({m_exp.name, ".func"}, {28'b0, alu_func}, {28'b0, m_exp.func});
                check({m_exp.name, ".rd"},   {27'b0, out_rd}, {27'b0, m_exp.rd});
                check({m_exp.name, ".wen"},  {31'b0, out_wen}, {31'b0, m_exp.wen});
                check({m_exp.name, ".ill"},  {31'b0, illegal}, {31'b0, m_exp.ill});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input exp_t e);
        bit accepted = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1_val = rs1; in_rs2_val = rs2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            n_total++;
            $display("FAIL %s_accept: got in_ready=0 for 50 cycles, expected acceptance", e.name);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        @(posedge clk); #1;
        check({name, "_drain_left"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
        flush = 1'b0; out_ready = 1'b0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in0",  alu_in0, 32'd0);
        check("rst_in1",  alu_in1, 32'd0);
        check("rst_func", {28'b0, alu_func}, 32'd0);
        check("rst_rd",   {27'b0, out_rd}, 32'd0);
        check("rst_wen",  {31'b0, out_wen}, 32'd0);
        check("rst_ill",  {31'b0, illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Streaming decode vectors
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0, "add"));
        check("add_latency_valid", {31'b0, out_valid}, 32'd1);
        issue(32'h40208233, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'h8, 5'd4, 1'b1, 1'b0, "sub"));
        issue(32'h40335293, 32'h0, 32'h80000000, 32'h0, mk(32'h80000000, 32'd3, 4'hD, 5'd5, 1'b1, 1'b0, "srai"));
        issue(32'h00209233, 32'h0, 32'h11, 32'h23, mk(32'h11, 32'd3, 4'h1, 5'd4, 1'b1, 1'b0, "sll"));
        issue(32'h0020D233, 32'h0, 32'hF0, 32'hFFFFFFE4, mk(32'hF0, 32'd4, 4'h5, 5'd4, 1'b1, 1'b0, "srl"));
        issue(32'hFFF00293, 32'h0, 32'h1234, 32'h55, mk(32'h0, 32'hFFFFFFFF, 4'h0, 5'd5, 1'b1, 1'b0, "addi_x0"));
        issue(32'h7FF0C313, 32'h0, 32'hAA, 32'h0, mk(32'hAA, 32'h7FF, 4'h4, 5'd6, 1'b1, 1'b0, "xori"));
        issue(32'h123453B7, 32'h0, 32'd9, 32'd9, mk(32'h0, 32'h12345000, 4'h0, 5'd7, 1'b1, 1'b0, "lui"));
        issue(32'hABCDE417, 32'h1000, 32'd9, 32'd9, mk(32'h1000, 32'hABCDE000, 4'h0, 5'd8, 1'b1, 1'b0, "auipc"));
        issue(32'h00208033, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'h0, 5'd0, 1'b0, 1'b0, "add_rd0"));
        issue(32'h0000007F, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1, "bad_opc"));
        issue(32'h022081B3, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 4'h0, 5'd3, 1'b0, 1'b1, "mul_ill"));
        issue(32'h40331293, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 4'h0, 5'd5, 1'b0, 1'b1, "slli_ill"));
`ifdef ALU_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hDEADBEEF;
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'hDEADBEEF, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0, "fwd_rs1"));
        fwd_rd = 5'd0;
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0, "fwd_x0"));
        fwd_rd = 5'd2; fwd_data = 32'hFFFFFF25;
        issue(32'h00209233, 32'h0, 32'h11, 32'h23, mk(32'h11, 32'd5, 4'h1, 5'd4, 1'b1, 1'b0, "fwd_sll"));
        fwd_valid = 1'b0;
`endif
        drain("stream");

        // Back-pressure: three pushes with the consumer stalled
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'h0, 5'd3, 1'b1, 1'b0, "fifo_a"));
        check("one_in_ready", {31'b0, in_ready}, 32'd1);
        issue(32'h002081B3, 32'h0, 32'd3, 32'd4, mk(32'd3, 32'd4, 4'h0, 5'd3, 1'b1, 1'b0, "fifo_b"));
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_hold_in0", alu_in0, 32'd1);
        fork
            issue(32'h002081B3, 32'h0, 32'd5, 32'd6, mk(32'd5, 32'd6, 4'h0, 5'd3, 1'b1, 1'b0, "fifo_c"));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("fifo");

        // Flush while full with a simultaneous push
        out_ready = 1'b0;
        issue(32'h00208033, 32'h0, 32'd11, 32'd12, mk(32'd11, 32'd12, 4'h0, 5'd0, 1'b0, 1'b0, "flush_d"));
        issue(32'h002081B3, 32'h0, 32'd13, 32'd14, mk(32'd13, 32'd14, 4'h0, 5'd3, 1'b1, 1'b0, "flush_e"));
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h40208233; in_rs1_val = 32'd99; in_rs2_val = 32'd1;
        q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready",  {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("flush_stays_empty", {31'b0, out_valid}, 32'd0);
        issue(32'h40208233, 32'h0, 32'd20, 32'd8, mk(32'd20, 32'd8, 4'h8, 5'd4, 1'b1, 1'b0, "post_flush"));
        drain("flush");

        // Asynchronous reset with an entry held
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'd42, 32'd43, mk(32'd42, 32'd43, 4'h0, 5'd3, 1'b1, 1'b0, "rst_lost"));
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'b0, in_ready}, 32'd0);
        check("arst_in0",       alu_in0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue(32'h123453B7, 32'h0, 32'd0, 32'd0, mk(32'h0, 32'h12345000, 4'h0, 5'd7, 1'b1, 1'b0, "post_rst"));
        drain("rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 in_valid  in  1  decode stage offers an instruction.
REQ-005 in_ready  out  1  block accepts; a transfer occurs when in_valid && in_ready at clk edge.
REQ-006 in_inst  in  32  RV32I instruction word.
REQ-007 in_pc  in  32  instruction address.
REQ-008 in_rs1_val, in_rs2_val  in  32 each  register-file read data.
REQ-009 flush  in  1  discard all held and incoming instructions.
REQ-010 out_valid  out  1  entry presented to ALU stage.
REQ-011 out_ready  in  1  ALU stage consumes; pop when out_valid && out_ready.
REQ-012 alu_in0, alu_in1  out  32 each  ALU operands.
REQ-013 alu_func  out  4  ALU opcode.
REQ-014 out_rd  out  5 destination register; out_wen  out  1 writeback enable; illegal  out  1 undecodable instruction.
REQ-015 fwd_valid  in  1, fwd_rd  in  5, fwd_data  in  32  ALU result bypass; present only with ALU_FWD_EN.

Function
REQ-016 alu_func encodings: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
REQ-017 OP (0110011): func={inst[30],funct3}, in0=rs1, in1=rs2; funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101 -> illegal.
REQ-018 OP-IMM (0010011): func={0,funct3} except funct3=101 -> {inst[30],101}; in1=sign-extended imm[11:0]; shifts use in1={27'b0,shamt}; shift with imm[11:5] not 0000000/0100000 (srai) or nonzero (slli) -> illegal.
REQ-019 Register shifts (OP funct3 001/101): in1={27'b0,rs2[4:0]}.
REQ-020 LUI: in0=0, in1={inst[31:12],12'b0}, func add. AUIPC: in0=in_pc, same in1, func add.
REQ-021 Any other opcode: illegal=1, out_wen=0, func add, operands 0; entry still flows through.
REQ-022 Source field x0 yields operand 0 regardless of in_rs*_val.
REQ-023 out_wen=1 iff legal and rd!=0.
REQ-024 Two-entry skid buffer; states EMPTY, ONE, FULL; push-only advances, pop-only retreats, push+pop holds state.
REQ-025 Latency: accepted instruction appears on outputs the following cycle when buffer was EMPTY or popping.
REQ-026 in_ready=0 in FULL and while rst asserted, else 1.
REQ-027 Outputs stable while out_valid && !out_ready; strict FIFO order.
REQ-028 flush: next state EMPTY, out_valid=0; same-cycle push discarded; flush overrides pop.

Reset
REQ-029 On rst: state EMPTY, out_valid=0, alu_in0=alu_in1=0, alu_func=0000, out_rd=0, out_wen=0, illegal=0; rst mid-transfer loses all entries.

Configuration
REQ-030 Macro ALU_FWD_EN defined: at acceptance, if fwd_valid && fwd_rd!=0 && fwd_rd==rs1/rs2 field, fwd_data replaces that operand (before REQ-019 masking).
REQ-031 Macro undefined: fwd_* ports absent; operands from in_rs*_val only.

Structure
REQ-032 Shared package alu_pkg holds func encodings, RV32I opcode constants, skid-state typedef, decoded-entry struct.
REQ-033 Combinational decoder is a sub-module alu_decode; alu_issue holds buffer, handshake, forwarding.

Verification
REQ-034 ADD 0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, in0=5, in1=7, func 0000, rd=3, wen=1.
REQ-035 SRAI 0x40335293, rs1=0x80000000 -> func 1101, in1=3, rd=5; OP SLL with rs2=0x23 -> in1=3.
REQ-036 out_ready=0, three back-to-back pushes -> in_ready=0 after second; release -> three entries in order, no loss/duplication.
REQ-037 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and incoming entries never emitted.
REQ-038 ALU_FWD_EN, ADD of REQ-034 with fwd_valid=1, fwd_rd=1, fwd_data=0xDEADBEEF -> in0=0xDEADBEEF; fwd_rd=0 or macro off -> in0=5.
REQ-039 inst 0x0000007F -> illegal=1, wen=0, func 0000; funct7 0000001 OP -> illegal=1.
